// File: rtl/reg_mem_responder_pkg.sv
// Shared constants for the register-to-memory responder: one-hot FSM encoding
// and the legal read-latency range.
package reg_mem_responder_pkg;

  localparam int unsigned IdxIdle   = 0;
  localparam int unsigned IdxInit   = 1;
  localparam int unsigned IdxAccess = 2;
  localparam int unsigned IdxAck    = 3;
  localparam int unsigned IdxDone   = 4;
  localparam int unsigned NumStates = 5;

  typedef enum logic [NumStates-1:0] {
    StIdle   = 5'b00001,
    StInit   = 5'b00010,
    StAccess = 5'b00100,
    StAck    = 5'b01000,
    StDone   = 5'b10000
  } state_e;

  localparam int unsigned RdLatMin    = 1;
  localparam int unsigned RdLatMax    = 4;
  localparam int unsigned LatCntWidth = 3;

endpackage

// File: rtl/reg_mem_responder_if.sv
// Request/acknowledge bus between a snapshot register initiator and the
// memory-side responder.
interface reg_mem_responder_if #(
  parameter int unsigned MEM_WIDTH   = 36,
  parameter int unsigned ENTRY_WIDTH = 7
);
  logic                   mem_req_vld;
  logic [ENTRY_WIDTH-1:0] mem_addr;
  logic                   mem_rd_en;
  logic                   mem_wr_en;
  logic [MEM_WIDTH-1:0]   mem_wr_data;
  logic [MEM_WIDTH-1:0]   mem_rd_data;
  logic                   mem_ack_vld;
  logic                   mem_err;

  modport master (
    output mem_req_vld, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
    input  mem_rd_data, mem_ack_vld, mem_err
  );

  modport slave (
    input  mem_req_vld, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
    output mem_rd_data, mem_ack_vld, mem_err
  );
endinterface

// File: rtl/reg_mem_array.sv
// Flop-based entry array: one write port, combinational read mux, entries
// reset asynchronously to RST_VALUE.
module reg_mem_array #(
  parameter int unsigned          MEM_WIDTH   = 36,
  parameter int unsigned          ENTRY_WIDTH = 7,
  parameter int unsigned          DEPTH       = 128,
  parameter logic [MEM_WIDTH-1:0] RST_VALUE   = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [ENTRY_WIDTH-1:0] wr_addr,
  input  logic [MEM_WIDTH-1:0]   wr_data,
  input  logic [ENTRY_WIDTH-1:0] rd_addr,
  output logic [MEM_WIDTH-1:0]   rd_data
);

  logic [MEM_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RST_VALUE;
      end
    end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (32'(rd_addr) < DEPTH) ? mem_q[rd_addr] : '0;

endmodule

// File: rtl/reg_mem_responder.sv
// Memory-side responder: accepts one request at a time, services reads with a
// configurable latency, and runs a soft-clear walk over the entry array.
module reg_mem_responder
  import reg_mem_responder_pkg::*;
#(
  parameter int unsigned          MEM_WIDTH   = 36,
  parameter int unsigned          ENTRY_WIDTH = 7,
  parameter int unsigned          DEPTH       = 128,
  parameter int unsigned          RD_LATENCY  = 1,
  parameter logic [MEM_WIDTH-1:0] RST_VALUE   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  reg_mem_responder_if.slave  bus,
  input  logic                init_start,
  output logic                init_busy
);

  if (RD_LATENCY < RdLatMin || RD_LATENCY > RdLatMax) begin : g_bad_latency
    $error("RD_LATENCY out of legal range");
  end

  state_e                 state_q, state_d;
  logic [ENTRY_WIDTH-1:0] addr_q, addr_d;
  logic [LatCntWidth-1:0] cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [ENTRY_WIDTH-1:0] idx_q, idx_d;
  logic                   pend_q, pend_d;
  logic [MEM_WIDTH-1:0]   rd_data_q;

  logic                   arr_we;
  logic [ENTRY_WIDTH-1:0] arr_waddr;
  logic [MEM_WIDTH-1:0]   arr_wdata;
  logic [ENTRY_WIDTH-1:0] arr_raddr;
  logic [MEM_WIDTH-1:0]   arr_rdata;
  logic                   rd_ld;
  logic                   rd_clr;

  logic in_range, is_err, is_rd, is_wr;

  assign in_range = 32'(bus.mem_addr) < DEPTH;
  assign is_err   = (bus.mem_rd_en & bus.mem_wr_en) | ~in_range;
  assign is_rd    = bus.mem_rd_en & ~bus.mem_wr_en & in_range;
  assign is_wr    = bus.mem_wr_en & ~bus.mem_rd_en & in_range;

  reg_mem_array #(
    .MEM_WIDTH  (MEM_WIDTH),
    .ENTRY_WIDTH(ENTRY_WIDTH),
    .DEPTH      (DEPTH),
    .RST_VALUE  (RST_VALUE)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (arr_we),
    .wr_addr(arr_waddr),
    .wr_data(arr_wdata),
    .rd_addr(arr_raddr),
    .rd_data(arr_rdata)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    idx_d     = idx_q;
    pend_d    = pend_q | init_start;
    arr_we    = 1'b0;
    arr_waddr = bus.mem_addr;
    arr_wdata = bus.mem_wr_data;
    arr_raddr = addr_q;
    rd_ld     = 1'b0;
    rd_clr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (init_start || pend_q) begin
          state_d = StInit;
          idx_d   = '0;
          pend_d  = 1'b0;
        end else if (bus.mem_req_vld) begin
          addr_d = bus.mem_addr;
          err_d  = is_err;
          cnt_d  = LatCntWidth'(RD_LATENCY);
          if (is_rd) begin
            state_d   = StAccess;
            arr_raddr = bus.mem_addr;
            rd_ld     = (RD_LATENCY == 1);
          end else begin
            // Writes, no-ops and errors all complete one cycle after accept.
            state_d = StAck;
            arr_we  = is_wr;
            rd_clr  = is_err & bus.mem_rd_en;
          end
        end
      end
      StAccess: begin
        cnt_d = cnt_q - 1'b1;
        // Capture one cycle before ack so data is stable when the initiator samples.
        rd_ld = (cnt_q == LatCntWidth'(2));
        if (cnt_q == LatCntWidth'(1)) begin
          state_d = StAck;
        end
      end
      StInit: begin
        arr_we    = 1'b1;
        arr_waddr = idx_q;
        arr_wdata = RST_VALUE;
        idx_d     = idx_q + 1'b1;
        if (idx_q == ENTRY_WIDTH'(DEPTH - 1)) begin
          state_d = StIdle;
        end
      end
      StAck: state_d = StDone;
      StDone: begin
        if (!bus.mem_req_vld) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      if (rd_clr) begin
        rd_data_q <= '0;
      end else if (rd_ld) begin
        rd_data_q <= arr_rdata;
      end
    end
  end

  assign bus.mem_rd_data = rd_data_q;
  assign bus.mem_ack_vld = (state_q == StAck);
  assign bus.mem_err     = (state_q == StAck) & err_q;
  assign init_busy       = (state_q == StInit);

endmodule

// File: tb/tb_reg_mem_responder.sv
// Directed bench for reg_mem_responder with DEPTH=100, RD_LATENCY=2.
module tb_reg_mem_responder;

  localparam int unsigned MW = 36;
  localparam int unsigned AW = 7;

  logic clk = 1'b0;
  logic rst_n;
  logic init_start;
  logic init_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_mem_responder_if #(.MEM_WIDTH(MW), .ENTRY_WIDTH(AW)) bus ();

  reg_mem_responder #(
    .MEM_WIDTH  (MW),
    .ENTRY_WIDTH(AW),
    .DEPTH      (100),
    .RD_LATENCY (2),
    .RST_VALUE  ('0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .init_start(init_start),
    .init_busy (init_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [MW-1:0] d);
    bus.mem_req_vld = vld;
    bus.mem_rd_en   = rd;
    bus.mem_wr_en   = wr;
    bus.mem_addr    = a;
    bus.mem_wr_data = d;
  endtask

  // Issues one request from IDLE; lat is the ack cycle relative to accept, -1 on timeout.
  task automatic do_req(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [MW-1:0] d, output int lat, output logic err,
                        output logic [MW-1:0] rdat);
    lat  = -1;
    err  = 1'b0;
    rdat = '0;
    drive(1'b1, rd, wr, a, d);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.mem_ack_vld) begin
        lat  = c;
        err  = bus.mem_err;
        rdat = bus.mem_rd_data;
        break;
      end
      tick();
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (bus.mem_rd_data !== 36'h0) begin n_bad++;
      $display("FAIL reset_rd_data got %h want 0", bus.mem_rd_data); end
    n_cmp++; if (bus.mem_ack_vld !== 1'b0) begin n_bad++;
      $display("FAIL reset_ack got %b want 0", bus.mem_ack_vld); end
    n_cmp++; if (bus.mem_err !== 1'b0) begin n_bad++;
      $display("FAIL reset_err got %b want 0", bus.mem_err); end
    n_cmp++; if (init_busy !== 1'b0) begin n_bad++;
      $display("FAIL reset_busy got %b want 0", init_busy); end
    tick();
  endtask

  task automatic test_write_read();
    int lat; logic err; logic [MW-1:0] rdat;
    do_req(1'b0, 1'b1, 7'd5, 36'h9_DEAD_BEEF, lat, err, rdat);
    n_cmp++; if (lat !== 1) begin n_bad++;
      $display("FAIL wr_ack_latency got %0d want 1", lat); end
    n_cmp++; if (err !== 1'b0) begin n_bad++;
      $display("FAIL wr_err got %b want 0", err); end
    // Read with per-cycle timing checks.
    drive(1'b1, 1'b1, 1'b0, 7'd5, '0);
    @(negedge clk);
    tick(); @(negedge clk);
    n_cmp++; if (bus.mem_ack_vld !== 1'b0) begin n_bad++;
      $display("FAIL rd_early_ack_a1 got %b want 0", bus.mem_ack_vld); end
    tick(); @(negedge clk);
    n_cmp++; if (bus.mem_rd_data !== 36'h9_DEAD_BEEF) begin n_bad++;
      $display("FAIL rd_data_a2 got %h want 9deadbeef", bus.mem_rd_data); end
    n_cmp++; if (bus.mem_ack_vld !== 1'b0) begin n_bad++;
      $display("FAIL rd_early_ack_a2 got %b want 0", bus.mem_ack_vld); end
    tick(); @(negedge clk);
    n_cmp++; if (bus.mem_ack_vld !== 1'b1 || bus.mem_err !== 1'b0) begin n_bad++;
      $display("FAIL rd_ack_a3 got ack=%b err=%b want ack=1 err=0", bus.mem_ack_vld, bus.mem_err);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.mem_rd_data !== 36'h9_DEAD_BEEF || bus.mem_ack_vld !== 1'b0) begin n_bad++;
        $display("FAIL rd_hold_%0d got data=%h ack=%b want 9deadbeef/0", i, bus.mem_rd_data,
                 bus.mem_ack_vld);
      end
      tick();
    end
  endtask

  task automatic test_held_req();
    int acks = 0; int lat = -1;
    drive(1'b1, 1'b0, 1'b1, 7'd7, 36'h123);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.mem_ack_vld) acks++;
      tick();
    end
    n_cmp++; if (acks !== 1) begin n_bad++;
      $display("FAIL held_ack_count got %0d want 1", acks); end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 7'd7, '0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.mem_ack_vld && lat < 0) lat = c;
      if (lat >= 0) break;
      tick();
    end
    n_cmp++; if (lat !== 3) begin n_bad++;
      $display("FAIL held_next_latency got %0d want 3", lat); end
    n_cmp++; if (bus.mem_rd_data !== 36'h123) begin n_bad++;
      $display("FAIL held_next_data got %h want 123", bus.mem_rd_data); end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_errors();
    int lat; logic err; logic [MW-1:0] rdat;
    do_req(1'b1, 1'b0, 7'd120, '0, lat, err, rdat);
    n_cmp++; if (lat !== 1 || err !== 1'b1) begin n_bad++;
      $display("FAIL err_range got lat=%0d err=%b want 1/1", lat, err); end
    n_cmp++; if (rdat !== 36'h0) begin n_bad++;
      $display("FAIL err_range_data got %h want 0", rdat); end
    do_req(1'b0, 1'b1, 7'd3, 36'h777, lat, err, rdat);
    do_req(1'b1, 1'b1, 7'd3, 36'h5A5, lat, err, rdat);
    n_cmp++; if (lat !== 1 || err !== 1'b1) begin n_bad++;
      $display("FAIL err_both_en got lat=%0d err=%b want 1/1", lat, err); end
    do_req(1'b1, 1'b0, 7'd3, '0, lat, err, rdat);
    n_cmp++; if (rdat !== 36'h777 || err !== 1'b0 || lat !== 3) begin n_bad++;
      $display("FAIL err_entry3_kept got %h err=%b lat=%0d want 777/0/3", rdat, err, lat); end
  endtask

  task automatic test_noop();
    int lat; logic err; logic [MW-1:0] rdat;
    do_req(1'b0, 1'b0, 7'd5, 36'hF_FFFF_FFFF, lat, err, rdat);
    n_cmp++; if (lat !== 1 || err !== 1'b0) begin n_bad++;
      $display("FAIL noop_ack got lat=%0d err=%b want 1/0", lat, err); end
    n_cmp++; if (rdat !== 36'h777) begin n_bad++;
      $display("FAIL noop_data got %h want 777", rdat); end
    do_req(1'b1, 1'b0, 7'd5, '0, lat, err, rdat);
    n_cmp++; if (rdat !== 36'h9_DEAD_BEEF) begin n_bad++;
      $display("FAIL noop_entry5 got %h want 9deadbeef", rdat); end
  endtask

  task automatic test_init();
    int lat; logic err; logic [MW-1:0] rdat;
    int busy_cnt = 0; int ack_busy = 0; int idle_c = -1; int ack_at = -1;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 1'b1, AW'(i), 36'hF, lat, err, rdat);
    end
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (init_busy) busy_cnt++;
      if (bus.mem_ack_vld && init_busy) ack_busy++;
      if (!init_busy && idle_c < 0) idle_c = 0;
      if (bus.mem_ack_vld && !init_busy) begin ack_at = idle_c; rdat = bus.mem_rd_data; break; end
      tick();
      if (idle_c >= 0) idle_c++;
      if (c == 10) drive(1'b1, 1'b1, 1'b0, 7'd0, '0);
    end
    n_cmp++; if (busy_cnt !== 100) begin n_bad++;
      $display("FAIL init_busy_cycles got %0d want 100", busy_cnt); end
    n_cmp++; if (ack_busy !== 0) begin n_bad++;
      $display("FAIL init_ack_while_busy got %0d want 0", ack_busy); end
    n_cmp++; if (ack_at !== 3) begin n_bad++;
      $display("FAIL init_pending_req_latency got %0d want 3", ack_at); end
    n_cmp++; if (rdat !== 36'h0) begin n_bad++;
      $display("FAIL init_entry0 got %h want 0", rdat); end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    for (int i = 1; i < 4; i++) begin
      do_req(1'b1, 1'b0, AW'(i), '0, lat, err, rdat);
      n_cmp++; if (rdat !== 36'h0 || lat !== 3) begin n_bad++;
        $display("FAIL init_entry%0d got %h lat=%0d want 0/3", i, rdat, lat); end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic err; logic [MW-1:0] rdat; int acks = 0;
    do_req(1'b0, 1'b1, 7'd9, 36'hABC, lat, err, rdat);
    do_req(1'b1, 1'b0, 7'd9, '0, lat, err, rdat);
    do_req(1'b0, 1'b0, 7'd9, '0, lat, err, rdat);
    drive(1'b1, 1'b1, 1'b0, 7'd5, '0);
    tick();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.mem_ack_vld) acks++;
      tick();
    end
    n_cmp++; if (acks !== 0) begin n_bad++;
      $display("FAIL rst_mid_ack got %0d want 0", acks); end
    n_cmp++; if (bus.mem_rd_data !== 36'h0 || init_busy !== 1'b0) begin n_bad++;
      $display("FAIL rst_mid_outputs got data=%h busy=%b want 0/0", bus.mem_rd_data, init_busy);
    end
    do_req(1'b1, 1'b0, 7'd9, '0, lat, err, rdat);
    n_cmp++; if (rdat !== 36'h0 || lat !== 3 || err !== 1'b0) begin n_bad++;
      $display("FAIL rst_mid_entry9 got %h lat=%0d err=%b want 0/3/0", rdat, lat, err); end
    do_req(1'b0, 1'b1, 7'd9, 36'h1_2345_6789, lat, err, rdat);
    do_req(1'b1, 1'b0, 7'd9, '0, lat, err, rdat);
    n_cmp++; if (rdat !== 36'h1_2345_6789) begin n_bad++;
      $display("FAIL rst_mid_after got %h want 123456789", rdat); end
  endtask

  initial begin
    rst_n      = 1'b0;
    init_start = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_write_read();
    test_held_req();
    test_errors();
    test_noop();
    test_init();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
